// File: rtl/image_ram_reader_pkg.sv
// Shared types and defaults for the image RAM read path.
package image_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_ADDRESS_WIDTH = 8;
    localparam int SKID_DEPTH        = 2;

    // Index counter must reach FRAME_LEN itself, so size it for len+1 values.
    function automatic int idx_width(input int frame_len);
        return (frame_len < 1) ? 1 : $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/image_ram_reader_skid_fifo2.sv
// Two-entry register FIFO that absorbs RAM read latency and stream backpressure.
// Entry 0 is always the head, so popData comes straight from a register.
module skid_fifo2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic [1:0]       count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             do_pop_s;
    logic             do_push_s;

    // Next entry contents and occupancy.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        do_pop_s  = pop & (count_q != 2'd0);
        do_push_s = push & ((count_q != 2'd2) | do_pop_s);
        if (flush) begin
            head_d  = {WIDTH{1'b0}};
            tail_d  = {WIDTH{1'b0}};
            count_d = 2'd0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = pushData;
                    end else begin
                        tail_d = pushData;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = pushData;
                    end else begin
                        head_d = tail_q;
                        tail_d = pushData;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            head_q  <= {WIDTH{1'b0}};
            tail_q  <= {WIDTH{1'b0}};
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign popData = head_q;
    assign count   = count_q;
    assign empty   = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);

endmodule

// File: rtl/image_ram_reader.sv
// Read-side master for the single-port image RAM: streams FRAME_LEN words from
// frameBase as a valid/ready stream with a last flag, one word per cycle at best.
module image_ram_reader
    import image_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int FRAME_LEN     = 256
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDRESS_WIDTH-1:0] frameBase,
    output logic                     ramWEn,
    output logic [ADDRESS_WIDTH-1:0] ramAddr,
    input  logic [DATA_WIDTH-1:0]    ramDataIn,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [DATA_WIDTH-1:0]    outData,
    output logic                     outLast,
    output logic                     busy,
    output logic                     done
);

    localparam int                 IDX_W    = idx_width(FRAME_LEN);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam int                 FW       = DATA_WIDTH + 1;
    localparam logic [2:0]         CREDITS  = 3'(SKID_DEPTH);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     in_flight_q, in_flight_d;
    logic                     last_flight_q, last_flight_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     fifo_push_s;
    logic                     fifo_pop_s;
    logic                     fifo_flush_s;
    logic [1:0]               fifo_count_s;
    logic                     fifo_empty_s;
    logic                     fifo_full_s;
    logic [FW-1:0]            fifo_head_s;

    logic                     credit_ok_s;
    logic                     issue_s;
    logic                     last_issue_s;
    logic                     drained_s;

    // Credit check, capture and drain detection. A pop this cycle frees a slot
    // for the read issued now, which is what sustains one word per cycle.
    always_comb begin
        fifo_pop_s   = ~fifo_empty_s & outReady;
        credit_ok_s  = (({1'b0, fifo_count_s} + {2'b00, in_flight_q}) < CREDITS) | fifo_pop_s;
        issue_s      = (state_q == RUN) & ~abort & credit_ok_s;
        last_issue_s = issue_s & (idx_q == LAST_IDX);
        fifo_flush_s = abort & (state_q != IDLE);
        fifo_push_s  = in_flight_q & (~fifo_full_s | fifo_pop_s);
        drained_s    = (state_q == DRAIN) & ~abort & ~in_flight_q &
                       ((fifo_count_s == 2'd0) | ((fifo_count_s == 2'd1) & fifo_pop_s));
        in_flight_d   = issue_s;
        last_flight_d = last_issue_s;
    end

    // Frame FSM, address/index counters and done pulse.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    state_d = RUN;
                    addr_d  = frameBase;
                    idx_d   = {IDX_W{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (issue_s) begin
                    idx_d = idx_q + IDX_W'(1);
                    // ramAddr keeps the final address once the frame is issued.
                    if (last_issue_s) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + ADDRESS_WIDTH'(1);
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (drained_s) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and counter registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= IDLE;
            addr_q        <= {ADDRESS_WIDTH{1'b0}};
            idx_q         <= {IDX_W{1'b0}};
            in_flight_q   <= 1'b0;
            last_flight_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            idx_q         <= idx_d;
            in_flight_q   <= in_flight_d;
            last_flight_q <= last_flight_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    skid_fifo2 #(
        .WIDTH (FW)
    ) u_skid (
        .clk      (clk),
        .rstN     (rstN),
        .flush    (fifo_flush_s),
        .push     (fifo_push_s),
        .pushData ({last_flight_q, ramDataIn}),
        .pop      (fifo_pop_s),
        .popData  (fifo_head_s),
        .count    (fifo_count_s),
        .empty    (fifo_empty_s),
        .full     (fifo_full_s)
    );

    assign ramWEn   = 1'b0;
    assign ramAddr  = addr_q;
    assign outValid = ~fifo_empty_s;
    assign outData  = fifo_head_s[DATA_WIDTH-1:0];
    assign outLast  = fifo_head_s[DATA_WIDTH];
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_image_ram_reader.sv
// Bench for image_ram_reader: three instances (FRAME_LEN 256, 4, 1) on identity RAMs,
// checked every cycle against a frame-level model of the expected word stream.
module tb_image_ram_reader;

    localparam int N_DUT = 3;

    function automatic int len_of(input int k);
        return (k == 0) ? 256 : ((k == 1) ? 4 : 1);
    endfunction

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_s     [N_DUT];
    logic       abort_s     [N_DUT];
    logic       out_ready_s [N_DUT];
    logic [7:0] base_s      [N_DUT];
    logic       ram_wen     [N_DUT];
    logic [7:0] ram_addr    [N_DUT];
    logic       out_valid   [N_DUT];
    logic [7:0] out_data    [N_DUT];
    logic       out_last    [N_DUT];
    logic       busy_s      [N_DUT];
    logic       done_s      [N_DUT];
    logic [7:0] mem         [256];

    int n_checks = 0;
    int n_errors = 0;

    // model state
    bit         act       [N_DUT];
    bit         pend_done [N_DUT];
    bit         rdy_all   [N_DUT];
    bit         stall_prev[N_DUT];
    logic [7:0] stall_data[N_DUT];
    logic       stall_last[N_DUT];
    logic [7:0] mbase     [N_DUT];
    int         midx      [N_DUT];
    int         c0        [N_DUT];
    logic [7:0] xlog_d    [N_DUT][16];
    logic       xlog_l    [N_DUT][16];
    int         cyc = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int L = (g == 0) ? 256 : ((g == 1) ? 4 : 1);
        logic [7:0] dout_q;

        image_ram_reader #(
            .DATA_WIDTH    (8),
            .ADDRESS_WIDTH (8),
            .FRAME_LEN     (L)
        ) u_dut (
            .clk       (clk),
            .rstN      (rst_n),
            .start     (start_s[g]),
            .abort     (abort_s[g]),
            .frameBase (base_s[g]),
            .ramWEn    (ram_wen[g]),
            .ramAddr   (ram_addr[g]),
            .ramDataIn (dout_q),
            .outValid  (out_valid[g]),
            .outReady  (out_ready_s[g]),
            .outData   (out_data[g]),
            .outLast   (out_last[g]),
            .busy      (busy_s[g]),
            .done      (done_s[g])
        );

        always @(posedge clk) begin
            if (!ram_wen[g]) dout_q <= mem[ram_addr[g]];
        end
    end

    task automatic chk(input bit ok, input string name, input int k, input longint got, input longint exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, k, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : cmp
        int   lenk;
        bit   xfer;
        bit   accept;
        logic [7:0] exp_d;
        logic [7:0] lead;
        if (!rst_n) begin
            for (int k = 0; k < N_DUT; k++) begin
                act[k] = 1'b0;
                pend_done[k] = 1'b0;
                stall_prev[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < N_DUT; k++) begin
                lenk = len_of(k);
                xfer = out_valid[k] && out_ready_s[k];
                chk(done_s[k] == pend_done[k], "done", k, done_s[k], pend_done[k]);
                chk(busy_s[k] == act[k], "busy", k, busy_s[k], act[k]);
                chk(ram_wen[k] == 1'b0, "ram_wen", k, ram_wen[k], 0);
                if (!act[k]) begin
                    chk(out_valid[k] == 1'b0, "idle_valid", k, out_valid[k], 0);
                end else if (rdy_all[k]) begin
                    chk(out_valid[k] == (cyc >= c0[k] + 3), "latency_valid", k, out_valid[k], cyc >= c0[k] + 3);
                end
                if (stall_prev[k]) begin
                    chk(out_valid[k] == 1'b1, "stall_valid", k, out_valid[k], 1);
                    chk(out_data[k] == stall_data[k] && out_last[k] == stall_last[k], "stall_hold", k,
                        {out_last[k], out_data[k]}, {stall_last[k], stall_data[k]});
                end
                if (act[k]) begin
                    lead = ram_addr[k] - mbase[k] - 8'(midx[k]);
                    chk(lead <= 8'd2, "addr_lead", k, lead, 2);
                end
                if (xfer && act[k]) begin
                    exp_d = mbase[k] + 8'(midx[k]);
                    chk(out_data[k] == exp_d, "data", k, out_data[k], exp_d);
                    chk(out_last[k] == (midx[k] == lenk - 1), "last", k, out_last[k], midx[k] == lenk - 1);
                    if (midx[k] < 16) begin
                        xlog_d[k][midx[k]] = out_data[k];
                        xlog_l[k][midx[k]] = out_last[k];
                    end
                    midx[k]++;
                end
                stall_prev[k] = out_valid[k] && !out_ready_s[k] && !(abort_s[k] && act[k]);
                stall_data[k] = out_data[k];
                stall_last[k] = out_last[k];
                accept = start_s[k] && !act[k] && !pend_done[k];
                if (act[k] && abort_s[k]) begin
                    act[k] = 1'b0;
                    pend_done[k] = 1'b0;
                end else if (act[k] && xfer && midx[k] == lenk) begin
                    act[k] = 1'b0;
                    pend_done[k] = 1'b1;
                end else begin
                    pend_done[k] = 1'b0;
                end
                if (act[k] && !out_ready_s[k]) rdy_all[k] = 1'b0;
                if (accept) begin
                    act[k] = 1'b1;
                    mbase[k] = base_s[k];
                    midx[k] = 0;
                    c0[k] = cyc;
                    rdy_all[k] = 1'b1;
                end
            end
            cyc++;
        end
    end

    task automatic run_frame(input int k, input logic [7:0] base, input bit rnd, input int abort_at,
                             input int stray_at, output int nx, output int busy_n, output bit got_done);
        bit aborted;
        nx = 0;
        busy_n = 0;
        got_done = 1'b0;
        aborted = 1'b0;
        base_s[k] = base;
        start_s[k] = 1'b1;
        if (!rnd) out_ready_s[k] = 1'b1;
        tick();
        start_s[k] = 1'b0;
        for (int c = 0; c < 3000 && !got_done && !aborted; c++) begin
            if (busy_s[k]) busy_n++;
            out_ready_s[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start_s[k] = (c == stray_at);
            base_s[k] = (c == stray_at) ? 8'h55 : base;
            abort_s[k] = (abort_at >= 0) && (nx == abort_at) && out_valid[k] && out_ready_s[k];
            aborted = abort_s[k];
            if (out_valid[k] && out_ready_s[k]) nx++;
            tick();
            start_s[k] = 1'b0;
            abort_s[k] = 1'b0;
            got_done = done_s[k];
        end
        if (abort_at < 0) chk(got_done, "done_timeout", k, got_done, 1);
    endtask

    initial begin
        int nx;
        int bn;
        bit gd;
        rst_n = 1'b0;
        for (int k = 0; k < N_DUT; k++) begin
            start_s[k] = 1'b0;
            abort_s[k] = 1'b0;
            out_ready_s[k] = 1'b1;
            base_s[k] = 8'h00;
        end
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            chk({out_valid[k], busy_s[k], done_s[k], out_last[k]} == 4'b0000, "reset_flags", k,
                {out_valid[k], busy_s[k], done_s[k], out_last[k]}, 0);
            chk(ram_addr[k] == 8'h00 && out_data[k] == 8'h00, "reset_bus", k, {ram_addr[k], out_data[k]}, 0);
        end
        rst_n = 1'b1;
        tick();
        tick();

        // 1: full frame, no backpressure
        run_frame(0, 8'h00, 1'b0, -1, -1, nx, bn, gd);
        chk(nx == 256, "t1_words", 0, nx, 256);
        chk(bn == 258, "t1_busy_cycles", 0, bn, 258);
        chk(xlog_d[0][0] == 8'h00 && xlog_d[0][3] == 8'h03, "t1_first", 0, {xlog_d[0][0], xlog_d[0][3]}, 16'h0003);

        // 2: address wrap, then start in the done cycle is ignored
        run_frame(1, 8'hFE, 1'b0, -1, -1, nx, bn, gd);
        chk({xlog_d[1][0], xlog_d[1][1], xlog_d[1][2], xlog_d[1][3]} == 32'hFEFF0001, "t2_words", 1,
            {xlog_d[1][0], xlog_d[1][1], xlog_d[1][2], xlog_d[1][3]}, 32'hFEFF0001);
        chk({xlog_l[1][0], xlog_l[1][1], xlog_l[1][2], xlog_l[1][3]} == 4'b0001, "t2_last", 1,
            {xlog_l[1][0], xlog_l[1][1], xlog_l[1][2], xlog_l[1][3]}, 1);
        chk(bn == 6, "t2_busy_cycles", 1, bn, 6);
        start_s[1] = 1'b1;
        tick();
        start_s[1] = 1'b0;
        chk(busy_s[1] == 1'b0, "start_on_done", 1, busy_s[1], 0);
        abort_s[1] = 1'b1;
        tick();
        abort_s[1] = 1'b0;
        chk(busy_s[1] == 1'b0 && out_valid[1] == 1'b0, "abort_idle", 1, {busy_s[1], out_valid[1]}, 0);

        // 3: random bases and backpressure
        for (int r = 0; r < 6; r++) begin
            run_frame(r % 2, 8'($urandom), 1'b1, -1, -1, nx, bn, gd);
            chk(nx == len_of(r % 2), "t3_words", r % 2, nx, len_of(r % 2));
            repeat ($urandom_range(0, 3)) tick();
        end

        // 4: abort at the 10th transfer, then a clean frame from 0x20
        run_frame(0, 8'h40, 1'b1, 9, -1, nx, bn, gd);
        chk(nx == 10, "t4_words", 0, nx, 10);
        chk({out_valid[0], busy_s[0], done_s[0]} == 3'b000, "t4_after_abort", 0,
            {out_valid[0], busy_s[0], done_s[0]}, 0);
        run_frame(0, 8'h20, 1'b1, -1, -1, nx, bn, gd);
        chk(xlog_d[0][0] == 8'h20 && xlog_d[0][1] == 8'h21, "t4_restart", 0, {xlog_d[0][0], xlog_d[0][1]}, 16'h2021);

        // 5: reset mid-frame, stray start, single-word frame
        base_s[0] = 8'h10;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            out_ready_s[0] = 1'($urandom_range(0, 1));
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk({out_valid[0], busy_s[0], done_s[0], out_last[0]} == 4'b0000, "t5_reset_flags", 0,
            {out_valid[0], busy_s[0], done_s[0], out_last[0]}, 0);
        chk(ram_addr[0] == 8'h00 && out_data[0] == 8'h00, "t5_reset_bus", 0, {ram_addr[0], out_data[0]}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        run_frame(0, 8'h80, 1'b1, -1, 3, nx, bn, gd);
        chk(nx == 256 && xlog_d[0][0] == 8'h80, "t5_stray", 0, {nx, xlog_d[0][0]}, {256, 8'h80});
        run_frame(2, 8'h33, 1'b0, -1, -1, nx, bn, gd);
        chk(nx == 1 && xlog_d[2][0] == 8'h33 && xlog_l[2][0] == 1'b1, "t5_len1", 2,
            {xlog_l[2][0], xlog_d[2][0]}, 9'h133);
        chk(bn == 3, "t5_len1_busy", 2, bn, 3);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
